// File: rtl/tthbif_cfg_pkg.sv
// Shared types and constants for the tthbif lane configuration register file.
package tthbif_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        RESP  = 2'd2
    } cfg_state_e;

    localparam logic [6:0] ADDR_STATUS  = 7'h7D;
    localparam logic [6:0] ADDR_SCRATCH = 7'h7E;
    localparam logic [6:0] ADDR_ID      = 7'h7F;

    localparam int CMD_WR_BIT = 7;

    localparam int STATUS_OVF_BIT = 0;
    localparam int STATUS_TMO_BIT = 1;

    localparam int LANE_COMB_MSB = 3;
    localparam int LANE_COMB_LSB = 2;
    localparam int LANE_FLOP_MSB = 1;
    localparam int LANE_FLOP_LSB = 0;

    localparam logic [3:0] LANE_RESET = 4'hF;

endpackage

// File: rtl/tthbif_cfg_rf.sv
// Byte-command register file driving the per-lane rx/tx tap selects.
// Two-byte writes (command, data) and one-byte reads answered over the UART tx path.
module tthbif_cfg_rf
    import tthbif_cfg_pkg::*;
#(
    parameter int         NUM_LANES      = 1,
    parameter int         TIMEOUT_CYCLES = 1048576,
    parameter logic [7:0] ID_VALUE       = 8'hB1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   rx_data_valid_i,
    input  logic [7:0]             rx_data_i,
    input  logic                   tx_data_ready_i,
    output logic                   tx_data_valid_o,
    output logic [7:0]             tx_data_o,
    output logic [2*NUM_LANES-1:0] rx_comb_tap_sel_o,
    output logic [2*NUM_LANES-1:0] rx_flop_tap_sel_o,
    output logic [2*NUM_LANES-1:0] tx_comb_tap_sel_o,
    output logic [2*NUM_LANES-1:0] tx_flop_tap_sel_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    if (NUM_LANES < 1 || NUM_LANES > 32) begin : g_bad_num_lanes
        $error("tthbif_cfg_rf: NUM_LANES must be within 1..32");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("tthbif_cfg_rf: TIMEOUT_CYCLES must be at least 2");
    end

    cfg_state_e        r_state;
    cfg_state_e        w_state_nxt;
    logic [6:0]        r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_rx_lane [NUM_LANES];
    logic [3:0]        r_tx_lane [NUM_LANES];
    logic [7:0]        r_scratch;
    logic [1:0]        r_status;
    logic              r_tx_valid;
    logic [7:0]        r_tx_data;

    logic              w_cmd_wr;
    logic              w_do_read;
    logic              w_do_write;
    logic              w_timeout;
    logic              w_overflow;
    logic              w_status_clr;
    logic [1:0]        w_status_set;
    logic [6:0]        w_rd_addr;
    logic [7:0]        w_rd_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_wr    = 1'b0;
        w_do_read   = 1'b0;
        w_do_write  = 1'b0;
        w_timeout   = 1'b0;
        w_overflow  = 1'b0;
        if (!en_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rx_data_valid_i) begin
                        if (rx_data_i[CMD_WR_BIT]) begin
                            w_cmd_wr    = 1'b1;
                            w_state_nxt = WDATA;
                        end else begin
                            w_do_read   = 1'b1;
                            w_state_nxt = RESP;
                        end
                    end
                end
                WDATA: begin
                    if (rx_data_valid_i) begin
                        w_do_write  = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                RESP: begin
                    w_overflow = rx_data_valid_i;
                    if (tx_data_ready_i) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Read address comes straight from the command byte; lanes occupy 2i (rx) and 2i+1 (tx).
    assign w_rd_addr = rx_data_i[6:0];

    always_comb begin
        w_rd_data = 8'h00;
        case (w_rd_addr)
            ADDR_STATUS:  w_rd_data = {6'b0, r_status};
            ADDR_SCRATCH: w_rd_data = r_scratch;
            ADDR_ID:      w_rd_data = ID_VALUE;
            default: begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (w_rd_addr == 7'(2 * i)) begin
                        w_rd_data = {4'b0, r_rx_lane[i]};
                    end
                    if (w_rd_addr == 7'(2 * i + 1)) begin
                        w_rd_data = {4'b0, r_tx_lane[i]};
                    end
                end
            end
        endcase
    end

    assign w_status_clr = w_do_read && (w_rd_addr == ADDR_STATUS);

    always_comb begin
        w_status_set                 = 2'b00;
        w_status_set[STATUS_OVF_BIT] = w_overflow;
        w_status_set[STATUS_TMO_BIT] = w_timeout;
    end

    // Counter runs only while waiting for a data byte, so it is zero on every WDATA entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt  <= '0;
            r_addr <= 7'h00;
        end else begin
            if (r_state == WDATA && w_state_nxt == WDATA) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (w_cmd_wr) begin
                r_addr <= rx_data_i[6:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_rx_lane[i] <= LANE_RESET;
                r_tx_lane[i] <= LANE_RESET;
            end
            r_scratch <= 8'h00;
        end else if (w_do_write) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (r_addr == 7'(2 * i)) begin
                    r_rx_lane[i] <= rx_data_i[3:0];
                end
                if (r_addr == 7'(2 * i + 1)) begin
                    r_tx_lane[i] <= rx_data_i[3:0];
                end
            end
            if (r_addr == ADDR_SCRATCH) begin
                r_scratch <= rx_data_i;
            end
        end
    end

    // A status event in the clearing cycle survives because set is OR-ed after the clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_status <= 2'b00;
        end else begin
            r_status <= (w_status_clr ? 2'b00 : r_status) | w_status_set;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else if (!en_i) begin
            r_tx_valid <= 1'b0;
        end else if (w_do_read) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_rd_data;
        end else if (r_state == RESP && tx_data_ready_i) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign tx_data_valid_o = r_tx_valid;
    assign tx_data_o       = r_tx_data;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign rx_comb_tap_sel_o[2*g+1 -: 2] = r_rx_lane[g][LANE_COMB_MSB:LANE_COMB_LSB];
        assign rx_flop_tap_sel_o[2*g+1 -: 2] = r_rx_lane[g][LANE_FLOP_MSB:LANE_FLOP_LSB];
        assign tx_comb_tap_sel_o[2*g+1 -: 2] = r_tx_lane[g][LANE_COMB_MSB:LANE_COMB_LSB];
        assign tx_flop_tap_sel_o[2*g+1 -: 2] = r_tx_lane[g][LANE_FLOP_MSB:LANE_FLOP_LSB];
    end

endmodule

// File: doc/tthbif_cfg_rf.md
Name: tthbif_cfg_rf

Overview:
- Byte-command register file that configures the per-lane tap selects of the tthbif rx/tx lanes, replacing the current hard-wired 2'b11 taps.
- Sits between the UART byte interface (rx valid/data, tx ready/valid/data) and the lane instances in the tthbif top.
- A host writes and reads lane tap registers, a scratch register, a status register and an ID register through a two-byte write / one-byte read protocol.

Parameters:
- NUM_LANES, 1, number of lanes configured; legal range 1..32 (elaboration error otherwise).
- TIMEOUT_CYCLES, 1048576, cycles allowed between a write command byte and its data byte; must be >= 2.
- ID_VALUE, 8'hB1, constant returned by the ID register.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  block enable; when low, the FSM is forced to IDLE, incoming bytes are ignored and registers are retained
- rx_data_valid_i  in  1  single-cycle strobe: a received byte is present
- rx_data_i  in  8  received byte
- tx_data_ready_i  in  1  UART transmitter can accept a byte
- tx_data_valid_o  out  1  response byte valid
- tx_data_o  out  8  response byte
- rx_comb_tap_sel_o  out  2*NUM_LANES  rx lane comb tap selects; lane i at [2i+1:2i]
- rx_flop_tap_sel_o  out  2*NUM_LANES  rx lane flop tap selects
- tx_comb_tap_sel_o  out  2*NUM_LANES  tx lane comb tap selects
- tx_flop_tap_sel_o  out  2*NUM_LANES  tx lane flop tap selects

Behaviour:
- Command byte: bit7 = 1 for write, 0 for read; bits[6:0] = address.
- Address map:
  - 2i = rx lane i; 2i+1 = tx lane i.
  - Lane register format: data[3:2] = comb tap, data[1:0] = flop tap. Bits [7:4] are ignored on write and read as 0. Reset value 4'hF, so all tap outputs reset to 2'b11.
  - 0x7D STATUS: bit0 = overflow, bit1 = timeout. Read-only; cleared on read. Reset 0.
  - 0x7E SCRATCH: read/write, 8 bits. Reset 0x00.
  - 0x7F ID: read-only, returns ID_VALUE.
  - Unmapped addresses: writes are ignored and reads return 0x00. Writes to STATUS and ID are ignored.
- FSM states: IDLE, WDATA, RESP. Reset state is IDLE.
  - IDLE, byte arrives with bit7 = 1: latch the address, clear the timeout counter, go to WDATA.
  - IDLE, byte arrives with bit7 = 0: capture the read data into tx_data_o and go to RESP. tx_data_valid_o = 1 on the next cycle.
  - WDATA, byte arrives: write it to the latched address; the register and its outputs update on the following cycle; go to IDLE.
  - WDATA, timeout: when the counter reaches TIMEOUT_CYCLES-1 with no byte, set STATUS.timeout, discard the command and go to IDLE.
  - RESP: hold tx_data_valid_o and tx_data_o stable until tx_data_ready_i; on the handshake cycle go to IDLE, with valid low on the next cycle.
  - RESP, byte arrives (including in the handshake cycle): the byte is dropped and STATUS.overflow is set.
- STATUS clear-on-read:
  - Clearing happens in the cycle the read command is accepted.
  - If an overflow or timeout event occurs in that same cycle, the set wins and the bit stays 1.
  - The returned byte is the pre-clear value.
- en_i low:
  - The FSM goes to IDLE, tx_data_valid_o drops, and any pending response is lost.
  - The timeout counter is held at 0.
  - Register contents and STATUS are unchanged.
- Reset values:
  - tx_data_valid_o = 0, tx_data_o = 0x00.
  - All tap outputs = all-ones.
  - SCRATCH = 0, STATUS = 0, state = IDLE.
  - Reset asserted mid-transaction: everything returns to these values immediately (asynchronous reset).
- Timeout counter: width $clog2(TIMEOUT_CYCLES); it must not wrap before expiry.

Decomposition:
- tthbif_cfg_pkg holds:
  - the state enum (IDLE/WDATA/RESP);
  - the address constants ADDR_STATUS = 7'h7D, ADDR_SCRATCH = 7'h7E, ADDR_ID = 7'h7F;
  - CMD_WR_BIT = 7;
  - the STATUS bit indices;
  - the lane field positions.
- No sub-module. The FSM, register array and counter live in one module of roughly 200 lines.

Test Plan:
- Reset, then read 0x7F -> tx_data_valid_o rises one cycle after the command strobe with tx_data_o = 0xB1, held through 5 cycles of ready low, and drops the cycle after ready.
- Write 0x81, 0x06 (tx lane 0 taps) -> the next cycle tx_comb_tap_sel_o[1:0] = 2'b01 and tx_flop_tap_sel_o[1:0] = 2'b10; rx lane 0 outputs remain 2'b11; a read of 0x01 returns 0x06.
- Write 0xFE, 0x5A, then read 0x7E -> 0x5A; write 0x90, 0x33 (unmapped address with NUM_LANES = 1) -> no output changes, and a read of 0x10 returns 0x00.
- Write command 0x80, then no byte for TIMEOUT_CYCLES (set to 16) -> FSM returns to IDLE and taps are unchanged; read 0x7D -> 0x02; a second read of 0x7D -> 0x00.
- Read 0x7F with ready held low, then strobe byte 0x00 -> byte dropped and the response is still 0xB1; after the handshake, read 0x7D -> 0x01.
- Drive en_i low during WDATA, then send data byte 0x05 -> ignored and taps unchanged. Reassert rst_ni low mid-RESP -> tx_data_valid_o drops asynchronously and all taps return to 2'b11.
